// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC and the instruction-memory port, hands the
// memory to a boot loader after reset, then sequences fetch with stall/redirect/halt.
module fetch_ctrl #(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               boot_i,
    input  logic               ld_valid_i,
    output logic               ld_ready_o,
    input  logic [PC_W-1:0]    ld_addr_i,
    input  logic [INSTR_W-1:0] ld_data_i,
    input  logic               ld_last_i,
    input  logic               stall_i,
    input  logic               pc_src_i,
    input  logic [PC_W-1:0]    pc_branch_i,
    input  logic               halt_i,
    output logic [PC_W-1:0]    imem_addr_o,
    output logic               imem_we_o,
    output logic [INSTR_W-1:0] imem_wdata_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               fd_en_o,
    output logic               fd_clr_o,
    output logic [1:0]         state_o,
    output logic [31:0]        fetch_cnt_o,
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        redirect_cnt_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_fetch_cnt;
    logic [31:0]     r_stall_cnt;
    logic [31:0]     r_redir_cnt;
    logic            w_ld_done;
    logic            w_run_halt;
    logic            w_run_redir;
    logic            w_run_stall;
    logic            w_run_fetch;

    assign w_ld_done = ld_valid_i && ld_last_i;

    // One-hot RUN action, resolved with halt > redirect > stall > fetch priority.
    always_comb begin
        w_run_halt  = 1'b0;
        w_run_redir = 1'b0;
        w_run_stall = 1'b0;
        w_run_fetch = 1'b0;
        if (r_state == S_RUN) begin
            if (halt_i)        w_run_halt  = 1'b1;
            else if (pc_src_i) w_run_redir = 1'b1;
            else if (stall_i)  w_run_stall = 1'b1;
            else               w_run_fetch = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = boot_i ? S_LOAD : S_RUN;
            S_LOAD:  if (w_ld_done) w_next = S_RUN;
            S_RUN:   if (w_run_halt) w_next = S_HALT;
            default: w_next = S_HALT;
        endcase
    end

    // Outputs decode from the registered state only, so a write can never leak out of LOAD.
    always_comb begin
        ld_ready_o  = 1'b0;
        imem_we_o   = 1'b0;
        imem_addr_o = r_pc;
        fd_en_o     = 1'b0;
        fd_clr_o    = 1'b1;
        case (r_state)
            S_LOAD: begin
                ld_ready_o  = 1'b1;
                imem_we_o   = ld_valid_i;
                imem_addr_o = ld_addr_i;
            end
            S_RUN: begin
                fd_en_o  = w_run_fetch;
                fd_clr_o = w_run_halt || w_run_redir;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= RESET_PC;
            r_fetch_cnt <= 32'd0;
            r_stall_cnt <= 32'd0;
            r_redir_cnt <= 32'd0;
        end else begin
            if ((r_state == S_IDLE) || ((r_state == S_LOAD) && w_ld_done))
                r_pc <= RESET_PC;
            else if (w_run_redir)
                r_pc <= pc_branch_i;
            else if (w_run_fetch)
                r_pc <= r_pc + {{(PC_W-1){1'b0}}, 1'b1};
            if (w_run_fetch) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (w_run_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (w_run_redir) r_redir_cnt <= r_redir_cnt + 32'd1;
        end
    end

    assign imem_wdata_o   = ld_data_i;
    assign pc_o           = r_pc;
    assign state_o        = r_state;
    assign fetch_cnt_o    = r_fetch_cnt;
    assign stall_cnt_o    = r_stall_cnt;
    assign redirect_cnt_o = r_redir_cnt;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Fetch-side controller that owns the program counter and the instruction-memory port and sequences the fetch stage. After reset it optionally gives the memory to a program loader, then runs the PC (word-addressed, +1 per instruction). It applies hazard stalls from DE, branch redirects from ME and a sticky halt, and drives the F/D pipeline latch enable and clear. It also keeps wrapping performance counters for fetches, stalls and redirects.

## Interface

- PC_W, 32, PC and memory word-address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, first PC fetched on entering RUN
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- boot_i  in  1  1 = enter LOAD after reset, 0 = go straight to RUN
- ld_valid_i  in  1  loader write request
- ld_ready_o  out  1  loader may write (1 only in LOAD)
- ld_addr_i  in  PC_W  loader word address
- ld_data_i  in  INSTR_W  loader write data
- ld_last_i  in  1  final loader word, qualified by ld_valid_i
- stall_i  in  1  hazard stall from DE: hold PC and F/D
- pc_src_i  in  1  branch taken, from ME
- pc_branch_i  in  PC_W  redirect target, from ME
- halt_i  in  1  stop fetching, sticky until reset
- imem_addr_o  out  PC_W  instruction-memory address (asynchronous read)
- imem_we_o  out  1  instruction-memory write enable
- imem_wdata_o  out  INSTR_W  instruction-memory write data
- pc_o  out  PC_W  current fetch PC, to F/D latch alongside the instruction
- fd_en_o  out  1  F/D latch load enable
- fd_clr_o  out  1  F/D latch loads a bubble (overrides fd_en_o)
- state_o  out  2  IDLE=0, LOAD=1, RUN=2, HALT=3
- fetch_cnt_o, stall_cnt_o, redirect_cnt_o  out  32 each  performance counters

## Operation

- States: IDLE, LOAD, RUN, HALT. Reset state is IDLE.
- **IDLE** (one cycle):
  - Next state is LOAD if boot_i=1, else RUN with pc_o=RESET_PC.
  - fd_clr_o=1.
- **LOAD**:
  - ld_ready_o=1, imem_addr_o=ld_addr_i, imem_wdata_o=ld_data_i, imem_we_o=ld_valid_i.
  - fd_clr_o=1, fd_en_o=0.
  - stall_i, pc_src_i and halt_i are ignored.
  - When ld_valid_i && ld_last_i, that word is written and the next state is RUN with pc_o=RESET_PC.
- **RUN**:
  - imem_addr_o=pc_o, imem_we_o=0, ld_ready_o=0.
  - Priority each cycle is halt_i > pc_src_i > stall_i > normal.
  - halt_i: next state HALT, pc_o holds, fd_clr_o=1.
  - pc_src_i: pc_o <= pc_branch_i, fd_clr_o=1 to squash the wrong-path fetch, redirect_cnt_o+1.
  - stall_i: pc_o holds, fd_en_o=0, fd_clr_o=0, stall_cnt_o+1.
  - normal: pc_o <= pc_o+1, fd_en_o=1, fetch_cnt_o+1.
- **HALT**:
  - pc_o frozen, fd_clr_o=1, imem_we_o=0, ld_ready_o=0.
  - All inputs are ignored. Only reset exits this state.
- Arithmetic:
  - PC increment is modulo 2^PC_W, so all-ones wraps to 0 with no special handling.
  - Counters are modulo 2^32 and wrap silently.
- imem_we_o is 1 only in LOAD with ld_valid_i=1. It is decoded from the registered state, so it is never 1 in any other state or during reset.

## Timing

- Reset values: state=IDLE, pc_o=RESET_PC, all counters 0, fd_en_o=0, fd_clr_o=1, ld_ready_o=0, imem_we_o=0, imem_addr_o=RESET_PC, imem_wdata_o=ld_data_i.
- Reset is asynchronous. Outputs take their reset values immediately on reset falling, including when reset arrives mid-LOAD or mid-RUN. A loader write in flight is dropped, with no partial write.
- Fetch latency is zero cycles. In RUN, instr(pc_o) is on the memory output in the same cycle and the F/D latch captures it together with pc_o on the next rising edge when fd_en_o=1.
- Redirect: if pc_src_i=1 in cycle N, pc_o=pc_branch_i in cycle N+1. The F/D latch holds a bubble during N+1, and instr(pc_branch_i) is in F/D from N+2.
- Stall held for k cycles: pc_o is unchanged for k cycles and F/D holds its contents. Fetch resumes in the first cycle with stall_i=0.
- Stall and redirect in the same cycle: the redirect is taken and stall_cnt_o does not increment.
- Redirect to the current pc_o is still counted and still bubbles.
- The loader's last write commits on the same edge that enters RUN. The first fetch, of RESET_PC, happens in the next cycle and reads the newly written data.

## Test plan

- Reset deassert with boot_i=0 -> state IDLE→RUN. pc_o sequence 0,1,2,3 on consecutive cycles. fd_en_o=1 from the first RUN cycle. fetch_cnt_o=4 after 4 RUN cycles.
- boot_i=1, loader writes addr 0..3 with data 0xA0..0xA3, ld_last_i on addr 3 -> imem_we_o=1 for exactly 4 cycles with the matching addr/data. ld_ready_o drops the cycle after the last write. imem_addr_o=0 in the first RUN cycle.
- In RUN at pc_o=5, assert stall_i for 3 cycles -> pc_o stays 5 for 3 cycles, then reads 6. stall_cnt_o=3, fd_en_o=0 during the stall.
- In RUN at pc_o=7, pc_src_i=1, pc_branch_i=0x40 together with stall_i=1 -> next pc_o=0x40 and fd_clr_o=1 for one cycle. redirect_cnt_o=1, stall_cnt_o unchanged.
- halt_i at pc_o=9 -> state HALT, pc_o stays 9 indefinitely and fd_clr_o=1. pc_src_i and stall_i have no effect. Reset returns state to IDLE with pc_o=RESET_PC.
- Assert reset mid-LOAD while ld_valid_i=1 -> imem_we_o=0 and ld_ready_o=0 immediately, and all counters read 0. With RESET_PC=0xFFFFFFFF and boot_i=0, pc_o goes 0xFFFFFFFF → 0 → 1.
